// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter / fetch controller for the single-cycle RV32I core.
//   Each cycle it picks the next instruction address from one of five
//   sources: trap vector, return-address stack, jump, branch or
//   sequential (pc + 4). It checks the chosen address for alignment and
//   range, and it keeps a circular return-address stack (RAS).
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   stall          hold PC, RAS and outputs (trap_req still acts)
//   branch_taken   redirect to branch_target
//   jump_valid     redirect to jump_target; with jump_is_call, push pc_plus4
//   ret_valid      redirect to the RAS top, or to jump_target if the RAS is empty
//   trap_req       force TRAP_VECTOR and leave FAULT
//   inst_address   current PC (registered)
//   pc_plus4       inst_address + 4 (combinational, wraps modulo 2^AW)
//   redirect       the last PC update was not sequential
//   fault          high while the FSM is in FAULT
//   fault_cause    00 none, 01 misaligned, 10 out of range
//   fault_addr     the address that caused the fault
//   ras_underflow  one-cycle pulse when a ret finds the RAS empty
//   state_dbg      FSM state for debug (0 RUN, 1 FAULT)
//
// Input qualification: there is no ready/valid handshake. A request
// (branch_taken, jump_valid, ret_valid) is used in the cycle it is high,
// only when stall=0 and the FSM is in RUN. Nothing is queued or retried.
module pc_fetch_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned MEM_SIZE      = 256,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDRESS_WIDTH-1:0] TRAP_VECTOR  = ADDRESS_WIDTH'('h10),
    parameter int unsigned RAS_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic                     jump_valid,
    input  logic                     jump_is_call,
    input  logic [ADDRESS_WIDTH-1:0] jump_target,
    input  logic                     ret_valid,
    input  logic                     trap_req,
    output logic [ADDRESS_WIDTH-1:0] inst_address,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic                     redirect,
    output logic                     fault,
    output logic [1:0]               fault_cause,
    output logic [ADDRESS_WIDTH-1:0] fault_addr,
    output logic                     ras_underflow,
    output logic                     state_dbg
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    // One bit wider than an address, so the limit still fits when
    // 4*MEM_SIZE equals 2^AW.
    localparam logic [AW:0] PC_LIMIT = (AW+1)'(4 * MEM_SIZE);

    typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;

    state_t          state;
    logic [AW-1:0]   ras [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;    // index of the current top entry
    logic [CW-1:0]   ras_count;

    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic            ras_empty;

    logic [AW-1:0]   cand;
    logic            cand_redirect;
    logic            do_pop;
    logic            do_push;
    logic            underflow;
    logic            misaligned;
    logic            out_of_range;
    logic            cand_ok;
    logic            update;     // this cycle's candidate is evaluated
    logic            accept;     // this cycle's candidate becomes the new PC

    logic            ras_we;
    logic [PW-1:0]   ras_waddr;

    assign pc_plus4  = inst_address + AW'(4);
    assign fault     = (state == S_FAULT);
    assign state_dbg = (state == S_FAULT);
    assign ras_empty = (ras_count == '0);
    assign ptr_inc   = (ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PW'(1);
    assign ptr_dec   = (ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr - PW'(1);

    // Pick the candidate address. A ret has priority over a jump. The
    // jump's call bit still counts with a ret, so a combined ret+call pops
    // the top and writes pc_plus4 back into the same slot.
    always_comb begin
        cand          = pc_plus4;
        cand_redirect = 1'b0;
        do_pop        = 1'b0;
        do_push       = 1'b0;
        underflow     = 1'b0;
        if (ret_valid) begin
            cand_redirect = 1'b1;
            do_push       = jump_valid & jump_is_call;
            if (!ras_empty) begin
                cand   = ras[ras_ptr];
                do_pop = 1'b1;
            end else begin
                cand      = jump_target;
                underflow = 1'b1;
            end
        end else if (jump_valid) begin
            cand          = jump_target;
            cand_redirect = 1'b1;
            do_push       = jump_is_call;
        end else if (branch_taken) begin
            cand          = branch_target;
            cand_redirect = 1'b1;
        end
    end

    assign misaligned   = (cand[1:0] != 2'b00);
    assign out_of_range = ({1'b0, cand} >= PC_LIMIT);
    assign cand_ok      = !misaligned && !out_of_range;
    assign update       = !rst && !trap_req && (state == S_RUN) && !stall;
    assign accept       = update && cand_ok;

    // When a push comes with a pop, it overwrites the popped slot.
    // Otherwise it advances the pointer. When the stack is full, the
    // advance lands on the oldest entry and overwrites it.
    assign ras_we    = accept && do_push;
    assign ras_waddr = do_pop ? ras_ptr : ptr_inc;

    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras[ras_waddr] <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_RUN;
            inst_address  <= RESET_VECTOR;
            redirect      <= 1'b0;
            fault_cause   <= 2'b00;
            fault_addr    <= '0;
            ras_underflow <= 1'b0;
            ras_ptr       <= '0;
            ras_count     <= '0;
        end else begin
            ras_underflow <= 1'b0;
            if (trap_req) begin
                state        <= S_RUN;
                inst_address <= TRAP_VECTOR;
                redirect     <= 1'b1;
                fault_cause  <= 2'b00;
                fault_addr   <= '0;
            end else if (update) begin
                ras_underflow <= underflow;
                if (cand_ok) begin
                    inst_address <= cand;
                    redirect     <= cand_redirect;
                    if (do_pop && !do_push) begin
                        ras_ptr   <= ptr_dec;
                        ras_count <= ras_count - CW'(1);
                    end else if (do_push && !do_pop) begin
                        ras_ptr <= ptr_inc;
                        if (ras_count != CW'(RAS_DEPTH)) begin
                            ras_count <= ras_count + CW'(1);
                        end
                    end
                end else begin
                    // PC and RAS stay as they are. Record the cause:
                    // misalignment takes precedence over range.
                    state       <= S_FAULT;
                    redirect    <= 1'b0;
                    fault_cause <= misaligned ? 2'b01 : 2'b10;
                    fault_addr  <= cand;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl with its default parameters.
module tb_pc_fetch_ctrl;

    localparam int EW = 69;  // {pc[32], redirect, fault, cause[2], faddr[32], underflow}

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic        jump_is_call;
    logic [31:0] jump_target;
    logic        ret_valid;
    logic        trap_req;
    logic [31:0] inst_address;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;
    logic        ras_underflow;
    logic        state_dbg;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_is_call  (jump_is_call),
        .jump_target   (jump_target),
        .ret_valid     (ret_valid),
        .trap_req      (trap_req),
        .inst_address  (inst_address),
        .pc_plus4      (pc_plus4),
        .redirect      (redirect),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .fault_addr    (fault_addr),
        .ras_underflow (ras_underflow),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the expected post-edge outputs.
    // The expectation is popped and compared 1 time unit after the edge.
    task automatic go(input logic s, input logic br, input logic [31:0] bt,
                      input logic jv, input logic jc, input logic [31:0] jt,
                      input logic rv, input logic tr,
                      input logic [31:0] e_pc, input logic e_rd, input logic e_f,
                      input logic [1:0] e_c, input logic [31:0] e_fa, input logic e_u);
        logic [EW-1:0] e;
        stall = s; branch_taken = br; branch_target = bt;
        jump_valid = jv; jump_is_call = jc; jump_target = jt;
        ret_valid = rv; trap_req = tr;
        exp_q.push_back({e_pc, e_rd, e_f, e_c, e_fa, e_u});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("inst_address", inst_address, e[68:37]);
        check_eq("redirect", {31'b0, redirect}, {31'b0, e[36]});
        check_eq("fault", {31'b0, fault}, {31'b0, e[35]});
        check_eq("fault_cause", {30'b0, fault_cause}, {30'b0, e[34:33]});
        check_eq("fault_addr", fault_addr, e[32:1]);
        check_eq("ras_underflow", {31'b0, ras_underflow}, {31'b0, e[0]});
        check_eq("pc_plus4", pc_plus4, e[68:37] + 32'd4);
    endtask

    task automatic idle(input logic [31:0] e_pc);
        go(0, 0, 0, 0, 0, 0, 0, 0, e_pc, 0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        // T1 reset and sequential fetch
        rst = 1'b1;
        go(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 0, 0);
        rst = 1'b0;
        idle(32'h4);
        idle(32'h8);
        idle(32'hc);

        // T2 range fault after the last legal word, then trap
        go(0, 0, 0, 1, 0, 32'd1012, 0, 0, 32'd1012, 1, 0, 2'b00, 0, 0);
        idle(32'd1016);
        idle(32'd1020);
        go(0, 0, 0, 0, 0, 0, 0, 0, 32'd1020, 0, 1, 2'b10, 32'd1024, 0);
        go(0, 0, 0, 1, 0, 32'h40, 0, 0, 32'd1020, 0, 1, 2'b10, 32'd1024, 0);
        go(0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1, 0, 2'b00, 0, 0);

        // T3 misaligned branch; a jump in FAULT is ignored
        go(0, 0, 0, 1, 0, 32'h8, 0, 0, 32'h8, 1, 0, 2'b00, 0, 0);
        go(0, 1, 32'h102, 0, 0, 0, 0, 0, 32'h8, 0, 1, 2'b01, 32'h102, 0);
        go(0, 0, 0, 1, 0, 32'h40, 0, 0, 32'h8, 0, 1, 2'b01, 32'h102, 0);
        go(0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1, 0, 2'b00, 0, 0);
        // misaligned and out of range together: misaligned wins
        go(0, 1, 32'h1002, 0, 0, 0, 0, 0, 32'h10, 0, 1, 2'b01, 32'h1002, 0);
        go(0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1, 0, 2'b00, 0, 0);

        // T4 stall holds everything (a call under stall must not push); trap overrides stall
        idle(32'h14);
        for (int i = 0; i < 3; i++)
            go(1, 1, 32'h40, 1, 1, 32'h80, 0, 0, 32'h14, 0, 0, 2'b00, 0, 0);
        go(1, 1, 32'h40, 0, 0, 0, 0, 1, 32'h10, 1, 0, 2'b00, 0, 0);

        // T5 RAS: the jump beats the branch; 5 calls into a depth-4 stack
        go(0, 1, 32'h40, 1, 0, 32'h0, 0, 0, 32'h0, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 1, 1, 32'h20, 0, 0, 32'h20, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 1, 1, 32'h40, 0, 0, 32'h40, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 1, 1, 32'h60, 0, 0, 32'h60, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 1, 1, 32'h80, 0, 0, 32'h80, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 1, 1, 32'h100, 0, 0, 32'h100, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 1, 0, 32'h300, 1, 0, 32'h84, 1, 0, 2'b00, 0, 0);  // ret beats the jump
        go(0, 0, 0, 0, 0, 0, 1, 0, 32'h64, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 0, 0, 0, 1, 0, 32'h44, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 0, 0, 0, 1, 0, 32'h24, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 0, 0, 32'h200, 1, 0, 32'h200, 1, 0, 2'b00, 0, 1);
        idle(32'h204);

        // T6 ret+call in the same cycle
        go(0, 0, 0, 1, 1, 32'h80, 0, 0, 32'h80, 1, 0, 2'b00, 0, 0);   // push 0x208
        go(0, 0, 0, 1, 1, 32'h30, 0, 0, 32'h30, 1, 0, 2'b00, 0, 0);   // push 0x84
        go(0, 0, 0, 1, 1, 32'h300, 1, 0, 32'h84, 1, 0, 2'b00, 0, 0);  // pop 0x84, top := 0x34
        go(0, 0, 0, 0, 0, 0, 1, 0, 32'h34, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 0, 0, 0, 1, 0, 32'h208, 1, 0, 2'b00, 0, 0);
        go(0, 0, 0, 0, 0, 32'h240, 1, 0, 32'h240, 1, 0, 2'b00, 0, 1);

        // Reset while in FAULT and while stalled
        go(0, 1, 32'h1, 0, 0, 0, 0, 0, 32'h240, 0, 1, 2'b01, 32'h1, 0);
        rst = 1'b1;
        go(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 0, 0);
        rst = 1'b0;
        idle(32'h4);
        rst = 1'b1;
        go(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 0, 0);
        rst = 1'b0;

        // Random stall cycles hold PC 0; sequential fetch resumes afterwards
        for (int i = 0; i < 8; i++) begin
            logic [31:0] bt;
            bt = 32'($urandom_range(0, 255)) << 2;
            go(1, 1, bt, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 0, 0);
        end
        idle(32'h4);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
